// File: rtl/muldiv_issue_ctrl_pkg.sv
// muldiv_issue_ctrl_pkg: shared funct3 codes, state encoding and cache key width
package muldiv_issue_ctrl_pkg;
   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;
   localparam int KEY_W = 3 + 64;
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      RESP  = 3'd3,
      DRAIN = 3'd4
   } state_t;
endpackage

// File: rtl/muldiv_result_cache.sv
// muldiv_result_cache: one-entry {funct3, rs1, rs2} -> result cache with combinational hit
module muldiv_result_cache
   import muldiv_issue_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [KEY_W-1:0] wkey,
   input  logic [31:0]      wdata,
   input  logic [KEY_W-1:0] lkey,
   output logic             hit,
   output logic [31:0]      rdata
);
   logic             valid;
   logic [KEY_W-1:0] key;
   logic [31:0]      data;
   // entry is only ever replaced, never invalidated outside reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         key   <= '0;
         data  <= '0;
      end else if (we) begin
         valid <= 1'b1;
         key   <= wkey;
         data  <= wdata;
      end
   end
   assign hit   = valid && (key == lkey);
   assign rdata = data;
endmodule

// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: issues RV32M ops to the shared mul/div unit and buffers results
module muldiv_issue_ctrl
   import muldiv_issue_ctrl_pkg::*;
#(
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 80
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_funct3,
   input  logic [31:0]      req_rs1,
   input  logic [31:0]      req_rs2,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             flush,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_data,
   output logic [TAG_W-1:0] resp_tag,
   output logic             timeout_err,
   output logic             md_start,
   output logic [31:0]      md_in_A,
   output logic [31:0]      md_in_B,
   output logic [1:0]       md_op_mul,
   output logic [1:0]       md_op_div,
   output logic             md_sel,
   input  logic [31:0]      md_R,
   input  logic             md_done
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   state_t           state, nxt;
   logic [2:0]       hold_f3;
   logic [31:0]      hold_a, hold_b, data_q;
   logic [TAG_W-1:0] hold_tag;
   logic [1:0]       op_mul_q, op_div_q;
   logic [CNT_W-1:0] cnt;
   logic             err_q, hit, accept, expired, busy, cache_we, wait_to, drain_to;
   logic [31:0]      cache_data;
   assign accept   = (state == IDLE) && req_valid && !flush;
   assign busy     = (state == WAIT) || (state == DRAIN);
   assign expired  = cnt >= CNT_W'(TIMEOUT - 1);
   assign cache_we = busy && md_done;
   assign wait_to  = (state == WAIT) && !md_done && !flush && expired;
   assign drain_to = (state == DRAIN) && !md_done && expired;
   muldiv_result_cache u_cache (
      .clk   (clk),
      .reset (reset),
      .we    (cache_we),
      .wkey  ({hold_f3, hold_a, hold_b}),
      .wdata (md_R),
      .lkey  ({req_funct3, req_rs1, req_rs2}),
      .hit   (hit),
      .rdata (cache_data)
   );
   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nxt;
   end
   // next state: flush drains in-flight ops since the unit cannot be aborted
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = accept ? (hit ? RESP : ISSUE) : IDLE;
         ISSUE:   nxt = flush ? DRAIN : WAIT;
         WAIT:    nxt = md_done ? (flush ? IDLE : RESP) : flush ? DRAIN : expired ? RESP : WAIT;
         RESP:    nxt = (flush || resp_ready) ? IDLE : RESP;
         DRAIN:   nxt = (md_done || expired) ? IDLE : DRAIN;
         default: nxt = IDLE;
      endcase
   end
   // handshake outputs decoded from state
   always_comb begin
      req_ready  = state == IDLE;
      md_start   = state == ISSUE;
      resp_valid = state == RESP;
   end
   // hold registers, result buffer, timeout counter and sticky error
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_f3  <= '0;
         hold_a   <= '0;
         hold_b   <= '0;
         hold_tag <= '0;
         op_mul_q <= '0;
         op_div_q <= '0;
         data_q   <= '0;
         cnt      <= '0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            hold_f3  <= req_funct3;
            hold_a   <= req_rs1;
            hold_b   <= req_rs2;
            hold_tag <= req_tag;
            op_mul_q <= req_funct3[2] ? op_mul_q : req_funct3[1:0];
            op_div_q <= req_funct3[2] ? req_funct3[1:0] : op_div_q;
         end
         if (accept && hit) data_q <= cache_data;
         else if (state == WAIT && md_done && !flush) data_q <= md_R;
         else if (wait_to) data_q <= '0;
         cnt <= busy ? cnt + 1'b1 : '0;
         if (wait_to || drain_to) err_q <= 1'b1;
      end
   end
   assign resp_data   = data_q;
   assign resp_tag    = hold_tag;
   assign timeout_err = err_q;
   assign md_in_A     = hold_a;
   assign md_in_B     = hold_b;
   assign md_op_mul   = op_mul_q;
   assign md_op_div   = op_div_q;
   assign md_sel      = hold_f3[2];
endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// tb_muldiv_issue_ctrl: directed checks of issue, cache, flush, backpressure and timeout
module tb_muldiv_issue_ctrl;
   import muldiv_issue_ctrl_pkg::*;
   localparam int TAG_W   = 5;
   localparam int TIMEOUT = 80;
   logic clk = 0, reset = 0;
   logic req_valid = 0, req_ready, flush = 0, resp_valid, resp_ready = 0, timeout_err;
   logic [2:0] req_funct3 = 0;
   logic [31:0] req_rs1 = 0, req_rs2 = 0, resp_data, md_in_A, md_in_B, md_R;
   logic [TAG_W-1:0] req_tag = 0, resp_tag;
   logic md_start, md_sel, md_done;
   logic [1:0] md_op_mul, md_op_div;
   int passed = 0, total = 0, lat = 3, mcnt;
   bit hang = 0, busy;

   muldiv_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
      .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_tag(resp_tag), .timeout_err(timeout_err), .md_start(md_start), .md_in_A(md_in_A),
      .md_in_B(md_in_B), .md_op_mul(md_op_mul), .md_op_div(md_op_div), .md_sel(md_sel),
      .md_R(md_R), .md_done(md_done)
   );

   always #5 clk = ~clk;

   // reference RV32M arithmetic used by the unit model
   function automatic logic [31:0] unit_f(logic sel, logic [1:0] om, logic [1:0] od, logic [31:0] a, logic [31:0] b);
      logic [2:0] f3;
      logic [63:0] sa, za, sb, zb, p;
      f3 = {sel, sel ? od : om};
      sa = {{32{a[31]}}, a}; za = {32'b0, a};
      sb = {{32{b[31]}}, b}; zb = {32'b0, b};
      p = 0;
      case (f3)
         F3_MUL:    p = {32'b0, a * b};
         F3_MULH:   p = {32'b0, 32'(((sa * sb) >> 32))};
         F3_MULHSU: p = {32'b0, 32'(((sa * zb) >> 32))};
         F3_MULHU:  p = {32'b0, 32'(((za * zb) >> 32))};
         F3_DIV:    p = {32'b0, (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b))};
         F3_DIVU:   p = {32'b0, (b == 0) ? 32'hFFFF_FFFF : a / b};
         F3_REM:    p = {32'b0, (b == 0) ? a : 32'($signed(a) % $signed(b))};
         F3_REMU:   p = {32'b0, (b == 0) ? a : a % b};
         default:   p = 0;
      endcase
      return p[31:0];
   endfunction

   // multi-cycle unit: done 'lat' cycles after the start cycle, reads operands at completion
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy <= 0; md_done <= 0; md_R <= 0; mcnt <= 0;
      end else begin
         md_done <= 0;
         if (md_start && !hang) begin
            busy <= 1; mcnt <= lat - 1;
         end else if (busy) begin
            if (mcnt == 1) begin
               busy <= 0; md_done <= 1;
               md_R <= unit_f(md_sel, md_op_mul, md_op_div, md_in_A, md_in_B);
            end else mcnt <= mcnt - 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else passed++;
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
      req_valid = 1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_tag = tag;
      tick;
      req_valid = 0;
   endtask

   task automatic wait_resp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            output int n, output int starts, output bit bad);
      n = 0; starts = 0; bad = 0;
      while (!resp_valid && n < 300) begin
         if (md_start) starts++;
         if (md_in_A !== a || md_in_B !== b || req_ready || md_sel !== f3[2] ||
             (f3[2] ? md_op_div : md_op_mul) !== f3[1:0]) bad = 1;
         tick; n++;
      end
   endtask

   task automatic deliver(input string name);
      resp_ready = 1;
      tick;
      resp_ready = 0;
      check({name, "_resp_drop"}, resp_valid, 0);
      check({name, "_ready_back"}, req_ready, 1);
   endtask

   task automatic op(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [TAG_W-1:0] tag, input int l, input bit exp_hit, input logic [31:0] exp);
      int n, starts;
      bit bad;
      lat = l;
      issue(f3, a, b, tag);
      wait_resp(f3, a, b, n, starts, bad);
      check({name, "_latency"}, n, exp_hit ? 0 : l + 1);
      check({name, "_starts"}, starts, exp_hit ? 0 : 1);
      check({name, "_stable"}, bad, 0);
      check({name, "_data"}, resp_data, exp);
      check({name, "_tag"}, resp_tag, tag);
      deliver(name);
   endtask

   initial begin
      int n, starts;
      bit bad, seen;
      repeat (2) tick;
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_md_start", md_start, 0);
      check("rst_timeout", timeout_err, 0);
      check("rst_resp_data", resp_data, 0);
      reset = 1;
      tick;
      op("mul_7x6", F3_MUL, 7, 6, 5'd5, 3, 0, 42);
      op("divu_100_7", F3_DIVU, 100, 7, 5'd6, 5, 0, 14);
      op("divu_hit", F3_DIVU, 100, 7, 5'd7, 5, 1, 14);
      op("div_100_7", F3_DIV, 100, 7, 5'd8, 6, 0, 14);
      op("rem_100_7", F3_REM, 100, 7, 5'd9, 4, 0, 2);
      // flush two cycles into WAIT: drains until done, never responds
      lat = 8;
      issue(F3_DIV, 50, 5, 5'd3);
      tick; tick;
      flush = 1;
      tick;
      flush = 0;
      n = 0; seen = 0;
      while (!req_ready && n < 40) begin
         if (resp_valid) seen = 1;
         tick; n++;
      end
      check("flush_drain_cycles", n, 6);
      check("flush_no_resp", seen | resp_valid, 0);
      op("drain_cached", F3_DIV, 50, 5, 5'd4, 8, 1, 10);
      op("mul_3x3", F3_MUL, 3, 3, 5'd10, 3, 0, 9);
      // response held under backpressure
      lat = 4;
      issue(F3_MUL, 3, 4, 5'd11);
      wait_resp(F3_MUL, 3, 4, n, starts, bad);
      bad = 0;
      repeat (5) begin
         if (!resp_valid || resp_data !== 12 || resp_tag !== 5'd11 || req_ready) bad = 1;
         tick;
      end
      check("hold_stable", bad, 0);
      check("hold_data", resp_data, 12);
      deliver("hold");
      // flush in RESP drops the response
      lat = 3;
      issue(F3_REMU, 100, 7, 5'd12);
      wait_resp(F3_REMU, 100, 7, n, starts, bad);
      check("remu_data", resp_data, 2);
      flush = 1;
      tick;
      flush = 0;
      check("resp_flush_drop", resp_valid, 0);
      check("resp_flush_ready", req_ready, 1);
      // flush with req_valid in IDLE: not accepted
      req_valid = 1; flush = 1; req_funct3 = F3_MUL; req_rs1 = 9; req_rs2 = 9;
      tick;
      req_valid = 0; flush = 0;
      check("idle_flush_ready", req_ready, 1);
      check("idle_flush_nostart", md_start, 0);
      tick;
      check("idle_flush_noresp", resp_valid, 0);
      // unit never finishes
      hang = 1;
      issue(F3_MULH, 5, 5, 5'd13);
      check("to_start", md_start, 1);
      repeat (TIMEOUT) tick;
      check("to_err_before", timeout_err, 0);
      check("to_resp_before", resp_valid, 0);
      tick;
      check("to_err", timeout_err, 1);
      check("to_resp", resp_valid, 1);
      check("to_data", resp_data, 0);
      deliver("to");
      check("to_sticky", timeout_err, 1);
      reset = 0;
      #1;
      check("rst2_err", timeout_err, 0);
      check("rst2_ready", req_ready, 1);
      hang = 0;
      tick;
      reset = 1;
      tick;
      op("post_rst_divu", F3_DIVU, 100, 7, 5'd14, 5, 0, 14);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- Sequences RV32M instructions from the execute stage into the shared multiply/divide unit.
- Owns the handshakes on both sides: latches operands and holds them stable for the whole operation, pulses start, waits for the done flag, then buffers the result until the pipeline accepts it.
- Handles flush of an in-flight operation by draining and discarding it, since the unit cannot be aborted.
- Keeps a one-entry result cache so that an identical repeated instruction completes without re-running the unit.

Parameters:
TAG_W, 5, width of destination-register tag carried with each request
TIMEOUT, 80, cycles to wait for done before declaring an error (must exceed the worst-case divide latency)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
req_valid  in  1  execute stage presents an M-extension op
req_ready  out  1  controller can accept a request this cycle
req_funct3  in  3  RV32M funct3 (000 MUL … 111 REMU)
req_rs1  in  32  operand A
req_rs2  in  32  operand B
req_tag  in  TAG_W  destination tag
flush  in  1  kill any accepted-but-not-delivered op
resp_valid  out  1  result available
resp_ready  in  1  writeback accepts result
resp_data  out  32  result
resp_tag  out  TAG_W  tag of result
timeout_err  out  1  sticky; set when the unit fails to finish in TIMEOUT cycles
md_start  out  1  start pulse to the unit
md_in_A  out  32  held operand A
md_in_B  out  32  held operand B
md_op_mul  out  2  funct3[1:0] when funct3[2]=0, else held
md_op_div  out  2  funct3[1:0] when funct3[2]=1, else held
md_sel  out  1  funct3[2] (1 = divide)
md_R  in  32  unit result
md_done  in  1  unit result valid; asserted no earlier than the cycle after md_start

Behaviour:
- Reset (async, active-low): state IDLE; every output is 0, except req_ready=1; cache invalid; timeout_err=0. Reset mid-operation abandons the op; the unit shares the same reset.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - req_ready=1.
  - On req_valid, latch funct3, rs1, rs2 and tag into the hold registers.
  - If the cache is valid and {funct3, rs1, rs2} matches the cache key: go to RESP with the cached data. No md_start is issued (1-cycle hit latency).
  - Otherwise go to ISSUE.
- ISSUE:
  - md_start=1 for exactly one cycle; md_* outputs are driven from the hold registers.
  - Go to WAIT; the timeout counter is cleared.
- WAIT:
  - md_in_A, md_in_B, md_op_* and md_sel stay stable (the unit's output formatting reads them combinationally).
  - On md_done: capture md_R into resp_data; write the cache key and data; cache becomes valid; go to RESP.
  - The counter increments each cycle. When it reaches TIMEOUT: set timeout_err, drive resp_data=0, go to RESP. The cache is not written.
- RESP:
  - resp_valid=1; resp_data and resp_tag are held.
  - On resp_ready: go to IDLE, and req_ready is high in the following cycle.
  - There is no back-to-back acceptance in the same cycle.
- Miss latency: request accepted at cycle 0, md_start at cycle 1, resp_valid at (done cycle + 1).
- Flush:
  - In IDLE: no effect.
  - In ISSUE or WAIT: go to DRAIN; the operation is not cancelled inside the unit.
  - In RESP: drop resp_valid and go to IDLE.
  - flush and req_valid in the same IDLE cycle: the request is not accepted.
- DRAIN:
  - req_ready=0; md operands stay held.
  - On md_done: write the cache (the result is still correct for its key), go to IDLE, resp_valid stays 0.
  - The timeout applies here too, but exits to IDLE.
- Simultaneous md_done and flush in WAIT: the result is cached but not delivered; go to IDLE.
- The cache is never invalidated except by reset. Its key includes all of funct3, so MUL and MULH with the same operands do not alias.
- Divide by zero and overflow are computed by the unit; the controller does not special-case them.

Decomposition:
- Shared package holds:
  - funct3 localparams (F3_MUL … F3_REMU);
  - state encoding (3-bit, IDLE=0);
  - the key width constant (3+64 bits).
- Natural sub-module: muldiv_result_cache. It is one entry: key/data registers, valid bit, combinational hit compare.

Test Plan:
- MUL 7*6, unit model done after 3 cycles → md_start one pulse at cycle 1; resp_data=42 one cycle after done; operands stable throughout WAIT.
- DIVU 100/7, then an identical DIVU with the same operands → first result 14; second result 14 one cycle after acceptance with no md_start.
- DIV then REM on the same operands → REM misses the cache; md_start reissued; REM 100%7=2.
- flush two cycles into WAIT of a DIV → resp_valid never rises; req_ready=0 until done; subsequent MUL 3*3 returns 9 normally.
- resp_ready held low 5 cycles in RESP → resp_valid, resp_data and resp_tag stable; req_ready=0 throughout.
- Unit model never asserts done → timeout_err=1 at cycle TIMEOUT of WAIT; resp_valid with data 0; reset clears timeout_err and restores req_ready=1.
